multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Main FSM of the multi-cycle CPU. Drives the ALU's 3-bit operation select as ALUControl2/ALUControl1/ALUControl0.
- Consumes the ALU's CarryOut/overflow/Negative/Zero outputs and holds them in an architectural NZCV register.
- Sequences fetch, decode, execute, memory and writeback, and generates every datapath strobe and mux select.

Parameters:
- IW, 16, instruction width. Opcode is instr[IW-1:IW-4]; S bit is instr[IW-5]; remaining bits are ignored here.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr  in  IW  current IR contents
- Zero, Negative, CarryOut, overflow  in  1 each  live ALU flags
- mem_ready  in  1  memory access complete
- ALUControl2, ALUControl1, ALUControl0  out  1 each  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 CLR
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  00=regB, 01=const 1, 10=immediate
- result_src  out  2  00=ALUOut reg, 01=mem data, 10=ALU direct
- adr_src  out  1  0=PC, 1=ALUOut
- pc_write, ir_write, reg_write, mem_write  out  1 each  write strobes
- flags_nzcv  out  4  architectural flags {N,Z,C,V}
- halted  out  1  CPU stopped

Behaviour:
- Clock and reset:
  - Single clock.
  - At a posedge with rst_n=0: state<=FETCH, flags_nzcv<=0.
  - While rst_n=0, pc_write/ir_write/reg_write/mem_write/halted are forced 0; all selects and ALUControl are 000/0.
  - Reset mid-instruction aborts it with no further strobes.
- Outputs are Moore, decoded from the state. Unlisted strobes are 0; unlisted selects are 0.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 XOR, 5 CLR, 6 CMP, 7 LDR, 8 STR, 9 B, 10 BEQ, 11 BNE, 12 BMI, 13 BCS, 14 BVS, 15 HALT.
- States:
  - FETCH: adr_src=0, ir_write=1, alu_src_a=0, alu_src_b=01, ALU=000, result_src=10, pc_write=1. Next: DECODE.
  - DECODE: no strobes. Next by opcode: 0-6 to EXECUTE; 7-8 to MEM_ADDR; 9-14 to BRANCH; 15 to HALT.
  - EXECUTE: alu_src_a=1, alu_src_b=00, ALU=opcode[2:0] (CMP uses 001). Flags update at end of this cycle (see flag rules). Next: ALU_WB for 0-5, FETCH for CMP.
  - ALU_WB: result_src=00, reg_write=1. Next: FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ALU=000. Next: MEM_READ for LDR, MEM_WRITE for STR.
  - MEM_READ: adr_src=1. Next: MEM_WB.
  - MEM_WB: result_src=01, reg_write=1. Next: FETCH.
  - MEM_WRITE: adr_src=1, mem_write=1. Next: FETCH.
  - BRANCH: alu_src_a=0, alu_src_b=10, ALU=000, result_src=10, pc_write=cond. Next: FETCH.
  - HALT: halted=1, no strobes. Stays in HALT until reset.
- Flag rules (latched at end of EXECUTE):
  - Update when S=1 or opcode=CMP.
  - ADD/SUB/CMP load all four flags from the ALU.
  - AND/ORR/XOR/CLR load N,Z only; C,V hold their values.
  - With S=0 and a non-CMP opcode, flags hold.
- Branch conditions use the registered flags, never live ALU flags:
  - B: always.
  - BEQ: Z=1. BNE: Z=0.
  - BMI: N=1. BCS: C=1. BVS: V=1.
- Latency in cycles:
  - ALU op: 4. CMP: 3.
  - LDR: 5. STR: 4.
  - Branch: 3, whether taken or not.

Optional Feature:
- MEM_WAIT_EN defined:
  - MEM_READ and MEM_WRITE hold their state and outputs while mem_ready=0.
  - mem_write stays asserted each wait cycle.
  - Exit on the cycle mem_ready=1.
  - FETCH likewise holds all outputs until mem_ready=1. ir_write/pc_write assert every held cycle; the PC increments only once because its enable is gated with mem_ready outside this block.
- MEM_WAIT_EN undefined: mem_ready is ignored and all memory states last one cycle.

Test Plan:
- Reset, then ADD S=1 with ALU returning Zero=1, CarryOut=1:
  - State order FETCH, DECODE, EXECUTE, ALU_WB; ALUControl=000 in EXECUTE.
  - reg_write=1 only in cycle 4.
  - flags_nzcv=0110.
- Flags=0110, then AND S=1 with ALU returning Negative=1, Zero=0 -> flags_nzcv=1010 (C kept at 1, V kept at 0).
- CMP (S=0) with ALU returning Zero=1 -> ALUControl=001 in EXECUTE, flags Z=1, reg_write never 1, back to FETCH after 3 cycles.
- Branch conditions:
  - Z=1: BEQ gives pc_write=1 in BRANCH; BNE gives pc_write=0.
  - Both take 3 cycles.
- LDR -> adr_src=1 in MEM_READ, result_src=01 with reg_write=1 in MEM_WB, 5 cycles total.
- MEM_WAIT_EN:
  - STR with mem_ready low for 3 cycles -> mem_write high for 4 cycles, then FETCH.
  - HALT -> halted=1 and held for 10+ cycles.
  - rst_n=0 one edge -> FETCH, halted=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Main sequencing FSM of the multi-cycle CPU. Walks each instruction through
//   fetch, decode, execute, memory and writeback, drives every datapath strobe
//   and mux select, selects the ALU operation and keeps the architectural
//   NZCV flag register that conditional branches test.
//
//   Optional build macro: MEM_WAIT_EN
//     defined   : FETCH, MEM_READ and MEM_WRITE hold until mem_ready=1.
//     undefined : mem_ready is ignored; every memory state lasts one cycle.
module multicycle_control_unit #(
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] instr,
    input  logic          Zero,
    input  logic          Negative,
    input  logic          CarryOut,
    input  logic          overflow,
    input  logic          mem_ready,
    output logic          ALUControl2,
    output logic          ALUControl1,
    output logic          ALUControl0,
    output logic          alu_src_a,
    output logic [1:0]    alu_src_b,
    output logic [1:0]    result_src,
    output logic          adr_src,
    output logic          pc_write,
    output logic          ir_write,
    output logic          reg_write,
    output logic          mem_write,
    output logic [3:0]    flags_nzcv,
    output logic          halted
);

    // Opcode map (instr[IW-1:IW-4])
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ORR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_CLR  = 4'd5;
    localparam logic [3:0] OP_CMP  = 4'd6;
    localparam logic [3:0] OP_LDR  = 4'd7;
    localparam logic [3:0] OP_STR  = 4'd8;
    localparam logic [3:0] OP_B    = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_BMI  = 4'd12;
    localparam logic [3:0] OP_BCS  = 4'd13;
    localparam logic [3:0] OP_BVS  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Mux select encodings
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXECUTE   = 4'd2,
        S_ALU_WB    = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_HALT      = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_flags;

    logic [3:0] w_opcode;
    logic       w_s_bit;
    logic       w_flag_upd;
    logic       w_flag_arith;
    logic       w_taken;
    logic       w_mem_go;
    logic [2:0] w_alu_ctrl;
    logic       w_unused;

    assign w_opcode = instr[IW-1:IW-4];
    assign w_s_bit  = instr[IW-5];

    // Operand bits of the instruction are consumed by the datapath, not here.
    assign w_unused = ^{instr[IW-6:0], mem_ready};

`ifdef MEM_WAIT_EN
    assign w_mem_go = mem_ready;
`else
    assign w_mem_go = 1'b1;
`endif

    // Flags are written by CMP always and by data ops only when S is set;
    // logical ops leave C and V alone.
    assign w_flag_upd   = (r_state == S_EXECUTE) && (w_s_bit || (w_opcode == OP_CMP));
    assign w_flag_arith = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                          (w_opcode == OP_CMP);

    assign flags_nzcv = r_flags;
    assign {ALUControl2, ALUControl1, ALUControl0} = w_alu_ctrl;

    // Branch condition evaluated against the registered flags only.
    always_comb begin
        w_taken = 1'b0;
        case (w_opcode)
            OP_B:    w_taken = 1'b1;
            OP_BEQ:  w_taken = r_flags[2];
            OP_BNE:  w_taken = ~r_flags[2];
            OP_BMI:  w_taken = r_flags[3];
            OP_BCS:  w_taken = r_flags[1];
            OP_BVS:  w_taken = r_flags[0];
            default: w_taken = 1'b0;
        endcase
    end

    // State register; reset restarts at FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Architectural NZCV register, latched at the end of EXECUTE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_flag_upd) begin
            if (w_flag_arith) begin
                r_flags <= {Negative, Zero, CarryOut, overflow};
            end else begin
                r_flags[3:2] <= {Negative, Zero};
            end
        end
    end

    // Next-state and Moore output decode; everything is quiet while in reset.
    always_comb begin
        w_next_state = r_state;
        w_alu_ctrl   = ALU_ADD;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_REGB;
        result_src   = RES_ALUOUT;
        adr_src      = 1'b0;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_FETCH: begin
                adr_src    = 1'b0;
                ir_write   = 1'b1;
                alu_src_a  = 1'b0;
                alu_src_b  = SRCB_ONE;
                w_alu_ctrl = ALU_ADD;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                if (w_mem_go) begin
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                if (w_opcode <= OP_CMP) begin
                    w_next_state = S_EXECUTE;
                end else if ((w_opcode == OP_LDR) || (w_opcode == OP_STR)) begin
                    w_next_state = S_MEM_ADDR;
                end else if (w_opcode == OP_HALT) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_BRANCH;
                end
            end

            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REGB;
                w_alu_ctrl = (w_opcode == OP_CMP) ? ALU_SUB : w_opcode[2:0];
                if (w_opcode == OP_CMP) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_ALU_WB;
                end
            end

            S_ALU_WB: begin
                result_src   = RES_ALUOUT;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                w_alu_ctrl = ALU_ADD;
                if (w_opcode == OP_STR) begin
                    w_next_state = S_MEM_WRITE;
                end else begin
                    w_next_state = S_MEM_READ;
                end
            end

            S_MEM_READ: begin
                adr_src = 1'b1;
                if (w_mem_go) begin
                    w_next_state = S_MEM_WB;
                end
            end

            S_MEM_WB: begin
                result_src   = RES_MEM;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (w_mem_go) begin
                    w_next_state = S_FETCH;
                end
            end

            S_BRANCH: begin
                alu_src_a    = 1'b0;
                alu_src_b    = SRCB_IMM;
                w_alu_ctrl   = ALU_ADD;
                result_src   = RES_ALU;
                pc_write     = w_taken;
                w_next_state = S_FETCH;
            end

            S_HALT: begin
                halted       = 1'b1;
                w_next_state = S_HALT;
            end

            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        if (!rst_n) begin
            w_alu_ctrl = 3'b000;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            result_src = 2'b00;
            adr_src    = 1'b0;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            halted     = 1'b0;
        end
    end

endmodule
